// File: rtl/uart_memloader.sv
// UART boot loader: assembles hex/binary words from the receiver and
// writes them to memory through a small FIFO while the CPU is held off.
module uart_memloader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4,
  parameter int HEX_UPPER  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        ready,
  input  logic        burst_en_cpu,
  input  logic [7:0]  burst_length_cpu,
  input  logic [31:0] a_cpu,
  input  logic [31:0] d_cpu,
  input  logic        we_cpu,
  input  logic        rd_cpu,
  output logic [31:0] spo_cpu,
  output logic        ready_cpu,
  output logic        burst_en_mem,
  output logic [7:0]  burst_length_mem,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  input  logic [7:0]  uart_data,
  input  logic        uart_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} rst_t;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} wst_t;

  rst_t        st_q, st_d;
  wst_t        wst_q, wst_d;
  logic [31:0] start_q, start_d, len_q, len_d;
  logic [31:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [31:0] csum_q, csum_d, bytes_q, bytes_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  nib_q, nib_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d, part_q, part_d;
  logic        ovf_q, ovf_d, abt_q, abt_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic        empty, full, push, push_ok, pop, abort, ctl;
  logic [31:0] head, push_w;
  logic        hex_ok;
  logic [3:0]  hex_nib;

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = fifo_q[rptr_q[AW-1:0]];
  assign ctl   = we && (a == 3'd3);
  assign abort = ctl && d[2] && (st_q != IDLE);

  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = uart_data[3:0];
    if (uart_data >= 8'h30 && uart_data <= 8'h39) begin
      hex_ok = 1'b1;
    end else if ((uart_data >= 8'h61 && uart_data <= 8'h66) ||
                 (HEX_UPPER != 0 && uart_data >= 8'h41 &&
                  uart_data <= 8'h46)) begin
      hex_ok  = 1'b1;
      hex_nib = uart_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      wst_q   <= W_IDLE;
      start_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      bytes_q <= '0;
      word_q  <= '0;
      nib_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      part_q  <= 1'b0;
      ovf_q   <= 1'b0;
      abt_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      st_q    <= st_d;
      wst_q   <= wst_d;
      start_q <= start_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      bytes_q <= bytes_d;
      word_q  <= word_d;
      nib_q   <= nib_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      part_q  <= part_d;
      ovf_q   <= ovf_d;
      abt_q   <= abt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q[AW-1:0]] <= push_w;
  end

  always_comb begin
    st_d    = st_q;
    wst_d   = wst_q;
    start_d = start_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    bytes_d = bytes_q;
    word_d  = word_q;
    nib_d   = nib_q;
    mode_d  = mode_q;
    done_d  = done_q;
    part_d  = part_q;
    ovf_d   = ovf_q;
    abt_d   = abt_q;
    push    = 1'b0;
    push_w  = '0;
    pop     = 1'b0;

    if (we && st_q == IDLE && a == 3'd1) start_d = d;
    if (we && st_q == IDLE && a == 3'd2) len_d = d;

    unique case (wst_q)
      W_IDLE:  if (!empty && ready_mem && !abort) wst_d = W_ISSUE;
      W_ISSUE: wst_d = W_WAIT;
      W_WAIT: if (ready_mem) begin
        wst_d  = W_IDLE;
        pop    = 1'b1;
        addr_d = addr_q + 32'(ADDR_STEP);
        cnt_d  = cnt_q + 32'd1;
        csum_d = csum_q + head;
      end
      default: wst_d = W_IDLE;
    endcase

    unique case (st_q)
      IDLE: if (ctl && d[0]) begin
        st_d    = RECV;
        mode_d  = d[1];
        addr_d  = start_q;
        cnt_d   = '0;
        csum_d  = '0;
        bytes_d = '0;
        word_d  = '0;
        nib_d   = '0;
        done_d  = 1'b0;
        part_d  = 1'b0;
        ovf_d   = 1'b0;
        abt_d   = 1'b0;
      end
      RECV: if (mode_q) begin
        if (bytes_q == len_q) begin
          st_d = FLUSH;
          if (nib_q != 3'd0) part_d = 1'b1;
        end else if (uart_ready) begin
          word_d  = {uart_data, word_q[31:8]};
          bytes_d = bytes_q + 32'd1;
          nib_d   = nib_q + 3'd1;
          if (nib_q == 3'd3) begin
            push   = 1'b1;
            push_w = word_d;
            nib_d  = '0;
          end
        end
      end else if (uart_ready) begin
        if (uart_data == 8'h20) begin
          st_d = FLUSH;
          if (nib_q != 3'd0) part_d = 1'b1;
        end else if (hex_ok) begin
          word_d = {word_q[27:0], hex_nib};
          nib_d  = nib_q + 3'd1;
          if (nib_q == 3'd7) begin
            push   = 1'b1;
            push_w = word_d;
            nib_d  = '0;
          end
        end
      end
      FLUSH: if (empty && wst_q == W_IDLE) begin
        st_d   = IDLE;
        done_d = !abt_q;
      end
      default: st_d = IDLE;
    endcase

    if (abort) begin
      st_d  = FLUSH;
      abt_d = 1'b1;
      nib_d = '0;
      push  = 1'b0;
    end
    if (push && full && !pop) ovf_d = 1'b1;
  end

  assign push_ok = push && (!full || pop);
  assign rptr_d  = rptr_q + (AW+1)'(pop);

  // An in-flight write keeps its head entry so the pop still lines up.
  always_comb begin
    wptr_d = wptr_q;
    if (abort) wptr_d = rptr_q + (AW+1)'(wst_q != W_IDLE);
    else if (push_ok) wptr_d = wptr_q + 1'b1;
  end

  always_comb begin
    ready            = st_q == IDLE;
    spo_cpu          = spo_mem;
    burst_en_mem     = 1'b0;
    burst_length_mem = '0;
    rd_mem           = 1'b0;
    ready_cpu        = 1'b0;
    we_mem           = wst_q == W_ISSUE;
    a_mem            = addr_q;
    d_mem            = head;
    if (st_q == IDLE) begin
      burst_en_mem     = burst_en_cpu;
      burst_length_mem = burst_length_cpu;
      rd_mem           = rd_cpu;
      ready_cpu        = ready_mem;
      we_mem           = we_cpu;
      a_mem            = a_cpu;
      d_mem            = d_cpu;
    end
    unique case (a)
      3'd0:    spo = {27'b0, abt_q, part_q, ovf_q, st_q != IDLE, done_q};
      3'd1:    spo = addr_q;
      3'd4:    spo = cnt_q;
      3'd5:    spo = csum_q;
      default: spo = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_memloader.sv
// Directed bench for uart_memloader: expected memory writes are queued
// ahead of each load and checked by a monitor as the DUT issues them.
module tb_uart_memloader;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        ready;
  logic        burst_en_cpu;
  logic [7:0]  burst_length_cpu;
  logic [31:0] a_cpu, d_cpu;
  logic        we_cpu, rd_cpu;
  logic [31:0] spo_cpu;
  logic        ready_cpu;
  logic        burst_en_mem;
  logic [7:0]  burst_length_mem;
  logic [31:0] a_mem, d_mem;
  logic        we_mem, rd_mem;
  logic [31:0] spo_mem;
  logic        ready_mem;
  logic [7:0]  uart_data;
  logic        uart_ready;

  int tests = 0;
  int fails = 0;
  int rcpu_bad = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  uart_memloader dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .ready(ready),
    .burst_en_cpu(burst_en_cpu), .burst_length_cpu(burst_length_cpu),
    .a_cpu(a_cpu), .d_cpu(d_cpu), .we_cpu(we_cpu), .rd_cpu(rd_cpu),
    .spo_cpu(spo_cpu), .ready_cpu(ready_cpu),
    .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem),
    .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem),
    .spo_mem(spo_mem), .ready_mem(ready_mem),
    .uart_data(uart_data), .uart_ready(uart_ready)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every loader write must match the queue head.
  always @(negedge clk) begin
    if (!rst && !ready) begin
      if (ready_cpu) rcpu_bad++;
      if (we_mem) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h@%h expected none",
                   d_mem, a_mem);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", a_mem, e[63:32]);
          chk("wr_data", d_mem, e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cw(input logic [2:0] ad, input logic [31:0] v);
    a = ad; d = v; we = 1'b1;
    tick();
    we = 1'b0; a = 3'd0; d = '0;
  endtask

  task automatic send(input logic [7:0] b);
    uart_data = b; uart_ready = 1'b1;
    tick();
    uart_ready = 1'b0;
    repeat (6) tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic rd(input logic [2:0] ad, input logic [31:0] exp,
                    input string name);
    a = ad;
    #1;
    chk(name, spo, exp);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (ready) break;
      tick();
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL %s: got ready=0 expected ready=1 (timeout)", name);
    end
  endtask

  task automatic queue_done(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; a = '0; d = '0; we = 1'b0;
    burst_en_cpu = 1'b0; burst_length_cpu = '0;
    a_cpu = '0; d_cpu = '0; we_cpu = 1'b0; rd_cpu = 1'b0;
    spo_mem = '0; ready_mem = 1'b1;
    uart_data = '0; uart_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_mem", 32'(we_mem), 32'd0);
    rd(3'd0, 32'h0, "rst_status");
    rd(3'd1, 32'h0, "rst_addr");
    rd(3'd4, 32'h0, "rst_count");
    rd(3'd5, 32'h0, "rst_csum");

    // hex load of two words
    exp_q.push_back({32'h100, 32'hDEADBEEF});
    exp_q.push_back({32'h104, 32'h12345678});
    cw(3'd1, 32'h100);
    cw(3'd3, 32'h1);
    chk("go_ready_low", 32'(ready), 32'd0);
    send_str("deadbeef12345678 ");
    wait_ready("hex_done");
    queue_done("hex_all_writes");
    rd(3'd0, 32'h1, "hex_status");
    rd(3'd4, 32'd2, "hex_count");
    rd(3'd5, 32'hF0E21567, "hex_csum");
    rd(3'd1, 32'h108, "hex_addr");

    // binary, LENGTH=6 leaves a partial word
    exp_q.push_back({32'h200, 32'h04030201});
    cw(3'd1, 32'h200);
    cw(3'd2, 32'd6);
    cw(3'd3, 32'h3);
    for (int i = 1; i <= 6; i++) send(8'(i));
    wait_ready("bin_done");
    queue_done("bin_all_writes");
    rd(3'd0, 32'h9, "bin_status");
    rd(3'd4, 32'd1, "bin_count");

    // memory stalled while 6 words arrive: 4 kept, 2 dropped
    exp_q.push_back({32'h300, 32'h04030201});
    exp_q.push_back({32'h304, 32'h08070605});
    exp_q.push_back({32'h308, 32'h0C0B0A09});
    exp_q.push_back({32'h30C, 32'h100F0E0D});
    ready_mem = 1'b0;
    cw(3'd1, 32'h300);
    cw(3'd2, 32'd24);
    cw(3'd3, 32'h3);
    for (int i = 1; i <= 24; i++) send(8'(i));
    repeat (30) tick();
    chk("ovf_still_busy", 32'(ready), 32'd0);
    ready_mem = 1'b1;
    wait_ready("ovf_done");
    queue_done("ovf_all_writes");
    rd(3'd0, 32'h5, "ovf_status");
    rd(3'd1, 32'h310, "ovf_addr");
    rd(3'd4, 32'd4, "ovf_count");

    // garbage ignored, space ends stream with partial word
    cw(3'd1, 32'h400);
    cw(3'd3, 32'h1);
    send_str("0g1Z2x3-4 5");
    wait_ready("junk_done");
    rd(3'd0, 32'h9, "junk_status");
    rd(3'd4, 32'd0, "junk_count");
    rd(3'd1, 32'h400, "junk_addr");

    // abort while a write waits for memory
    exp_q.push_back({32'h500, 32'hCAFEF00D});
    cw(3'd1, 32'h500);
    cw(3'd3, 32'h1);
    send_str("cafef00");
    uart_data = 8'h64; uart_ready = 1'b1;
    tick();
    uart_ready = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (we_mem) begin
          seen = 1'b1;
          break;
        end
      end
      ready_mem = 1'b0;
      chk("abort_we_seen", 32'(seen), 32'd1);
    end
    tick();
    send_str("11112222");
    cw(3'd3, 32'h4);
    repeat (5) tick();
    chk("abort_waits_write", 32'(ready), 32'd0);
    ready_mem = 1'b1;
    wait_ready("abort_done");
    repeat (10) tick();
    queue_done("abort_all_writes");
    rd(3'd0, 32'h10, "abort_status");
    rd(3'd4, 32'd1, "abort_count");
    rd(3'd5, 32'hCAFEF00D, "abort_csum");
    rd(3'd1, 32'h504, "abort_addr");

    // CPU passthrough in IDLE
    rd_cpu = 1'b1; a_cpu = 32'h1234; spo_mem = 32'hA5A55A5A;
    #1;
    chk("pt_rd_mem", 32'(rd_mem), 32'd1);
    chk("pt_a_mem", a_mem, 32'h1234);
    chk("pt_spo_cpu", spo_cpu, 32'hA5A55A5A);
    chk("pt_ready_cpu", 32'(ready_cpu), 32'd1);
    rd_cpu = 1'b0;
    spo_mem = '0;

    // address wraps past 2^32; CPU held off during load
    rd_cpu = 1'b1;
    rcpu_bad = 0;
    exp_q.push_back({32'hFFFFFFFC, 32'hA5A5A5A5});
    exp_q.push_back({32'h00000000, 32'h01234567});
    cw(3'd1, 32'hFFFFFFFC);
    cw(3'd3, 32'h1);
    send_str("a5a5a5a501234567 ");
    wait_ready("wrap_done");
    rd_cpu = 1'b0;
    queue_done("wrap_all_writes");
    chk("wrap_ready_cpu_low", 32'(rcpu_bad), 32'd0);
    rd(3'd0, 32'h1, "wrap_status");
    rd(3'd1, 32'h4, "wrap_addr");
    rd(3'd5, 32'hA6C8EB0C, "wrap_csum");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
